gemm_tile_engine: RTL and testbench

GEMM_TILE_ENGINE -- requirements
Module: gemm_tile_engine

---
 rtl/gemm_pkg.sv | 21 ++
 rtl/mac_cell.sv | 59 +++++
 rtl/gemm_tile_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_gemm_tile_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM tile engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package gemm_pkg;

  // Engine control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } gemm_state_e;

  // Zero-injection cycles after the last operand beat. The last beat
  // reaches cell (rows-1, cols-1) rows+cols-2 advances after entering the
  // array; one further advance leaves every pass register holding zero.
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/mac_cell.sv
// One systolic processing element: registered a/b pass-through plus a signed accumulator.
// Latency: a/b appear at a_o/b_o one advance later; acc_o updates on the advancing edge.
// Backpressure: every register holds when adv_i is low; clears take priority over advance.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   adv_i                 advance enable for pass registers and accumulator
//   clr_pass_i            zero the pass registers (start of a command)
//   clr_acc_i             zero the accumulator (start of a command with clear)
//   a_i / b_i             operands from the left / above neighbour
//   a_o / b_o             registered operands towards right / below neighbour
//   acc_o                 running sum of products
module mac_cell #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         adv_i,
  input  logic                         clr_pass_i,
  input  logic                         clr_acc_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] a_o,
  output logic signed [DATA_WIDTH-1:0] b_o,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;

  // Operands widened before the multiply so the full signed product is kept.
  assign prod     = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
  // Sign-extend; the sum below wraps in two's complement.
  assign prod_ext = ACC_WIDTH'(prod);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_o   <= '0;
      b_o   <= '0;
      acc_o <= '0;
    end else begin
      if (clr_pass_i) begin
        a_o <= '0;
        b_o <= '0;
      end else if (adv_i) begin
        a_o <= a_i;
        b_o <= b_i;
      end

      if (clr_acc_i) begin
        acc_o <= '0;
      end else if (adv_i) begin
        acc_o <= acc_o + prod_ext;
      end
    end
  end

endmodule

// File: rtl/gemm_tile_engine.sv
// Output-stationary ROWS x COLS systolic GEMM tile: A flows right, B flows down, C stays in cells.
// Latency: command accept to last result row = K + ROWS + COLS + ROWS cycles with no stalls.
// Backpressure: in_valid_i low freezes the array; out_ready_i low holds the current result row.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o          command handshake (IDLE only)
//   cmd_k_i, cmd_clear_i             reduction length, zero accumulators at accept
//   in_valid_i/in_ready_o            operand beat handshake (LOAD only)
//   in_a_i, in_b_i                   A column vector / B row vector, lane 0 in LSBs
//   out_valid_o/out_ready_i          result row handshake (DRAIN only)
//   out_data_o, out_row_o, out_last_o  one accumulator row, its index, last-row flag
//   busy_o                           high whenever not IDLE
module gemm_tile_engine
  import gemm_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int KLEN_W     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [KLEN_W-1:0]         cmd_k_i,
  input  logic                      cmd_clear_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [ROWS*DATA_WIDTH-1:0] in_a_i,
  input  logic [COLS*DATA_WIDTH-1:0] in_b_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [COLS*ACC_WIDTH-1:0] out_data_o,
  output logic [$clog2(ROWS)-1:0]   out_row_o,
  output logic                      out_last_o,
  output logic                      busy_o
);

  localparam int RW        = $clog2(ROWS);
  localparam int FLUSH_LEN = flush_len(ROWS, COLS);
  localparam int FL_W      = $clog2(FLUSH_LEN + 1);
  localparam int ROW_BITS  = COLS * ACC_WIDTH;

  gemm_state_e         state_q;
  logic [KLEN_W-1:0]   k_q;
  logic [KLEN_W-1:0]   beat_q;
  logic [FL_W-1:0]     flush_q;
  logic                out_valid_q;
  logic [ROW_BITS-1:0] out_data_q;
  logic [RW-1:0]       out_row_q;
  logic                out_last_q;

  logic cmd_fire;
  logic adv;
  logic clr_acc;

  assign cmd_fire = (state_q == ST_IDLE) && cmd_valid_i;
  // The array moves on every accepted beat and on every flush cycle.
  assign adv      = ((state_q == ST_LOAD) && in_valid_i) || (state_q == ST_FLUSH);
  assign clr_acc  = cmd_fire && cmd_clear_i;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign in_ready_o  = (state_q == ST_LOAD);
  assign busy_o      = (state_q != ST_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_row_o   = out_row_q;
  assign out_last_o  = out_last_q;

  // Horizontal (A) and vertical (B) operand links; index 0 is the skewed
  // array input, the extra last index is the unused edge output.
  logic signed [DATA_WIDTH-1:0] a_h [ROWS][COLS+1];
  logic signed [DATA_WIDTH-1:0] b_v [ROWS+1][COLS];
  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_flat;

  // Row r of A is delayed r advances so operands meet on the anti-diagonal.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew_a
    logic signed [DATA_WIDTH-1:0] a_inj;
    // Zeros are injected outside LOAD, which is what flushes the array.
    assign a_inj = (state_q == ST_LOAD) ? in_a_i[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_direct
      assign a_h[0][0] = a_inj;
    end else begin : g_delay
      logic signed [DATA_WIDTH-1:0] sk [r];
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          for (int i = 0; i < r; i++) sk[i] <= '0;
        end else if (cmd_fire) begin
          for (int i = 0; i < r; i++) sk[i] <= '0;
        end else if (adv) begin
          sk[0] <= a_inj;
          for (int i = 1; i < r; i++) sk[i] <= sk[i-1];
        end
      end
      assign a_h[r][0] = sk[r-1];
    end
  end

  // Column c of B is delayed c advances.
  for (genvar c = 0; c < COLS; c++) begin : g_skew_b
    logic signed [DATA_WIDTH-1:0] b_inj;
    assign b_inj = (state_q == ST_LOAD) ? in_b_i[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (c == 0) begin : g_direct
      assign b_v[0][0] = b_inj;
    end else begin : g_delay
      logic signed [DATA_WIDTH-1:0] sk [c];
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          for (int i = 0; i < c; i++) sk[i] <= '0;
        end else if (cmd_fire) begin
          for (int i = 0; i < c; i++) sk[i] <= '0;
        end else if (adv) begin
          sk[0] <= b_inj;
          for (int i = 1; i < c; i++) sk[i] <= sk[i-1];
        end
      end
      assign b_v[0][c] = sk[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [ACC_WIDTH-1:0] acc_cell;
      mac_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_cell (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .adv_i      (adv),
        .clr_pass_i (cmd_fire),
        .clr_acc_i  (clr_acc),
        .a_i        (a_h[r][c]),
        .b_i        (b_v[r][c]),
        .a_o        (a_h[r][c+1]),
        .b_o        (b_v[r+1][c]),
        .acc_o      (acc_cell)
      );
      assign acc_flat[(r*COLS+c)*ACC_WIDTH +: ACC_WIDTH] = acc_cell;
    end
  end

  // Row to load into the output register next: row 0 on the first DRAIN
  // cycle, otherwise the row after the one currently presented.
  logic [RW-1:0]       sel_row;
  logic [ROW_BITS-1:0] sel_data;

  always_comb begin
    sel_row  = out_valid_q ? (out_row_q + RW'(1)) : '0;
    sel_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (sel_row == RW'(r)) sel_data = acc_flat[r*ROW_BITS +: ROW_BITS];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      flush_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            k_q     <= cmd_k_i;
            beat_q  <= '0;
            flush_q <= '0;
            state_q <= (cmd_k_i != '0) ? ST_LOAD : ST_DRAIN;
          end
        end
        ST_LOAD: begin
          if (in_valid_i) begin
            if (beat_q == k_q - KLEN_W'(1)) begin
              beat_q  <= '0;
              state_q <= ST_FLUSH;
            end else begin
              beat_q <= beat_q + KLEN_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (flush_q == FL_W'(FLUSH_LEN - 1)) begin
            flush_q <= '0;
            state_q <= ST_DRAIN;
          end else begin
            flush_q <= flush_q + FL_W'(1);
          end
        end
        ST_DRAIN: begin
          // The first DRAIN cycle only loads row 0; valid then stays high
          // until the last row is taken, so !out_valid_q marks that cycle.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_row_q   <= sel_row;
            out_data_q  <= sel_data;
            out_last_q  <= (sel_row == RW'(ROWS - 1));
          end else if (out_ready_i) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_row_q   <= '0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              out_row_q  <= sel_row;
              out_data_q <= sel_data;
              out_last_q <= (sel_row == RW'(ROWS - 1));
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_tile_engine.sv
module tb_gemm_tile_engine;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int KW   = 16;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = COLS * AW;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic               cmd_valid_i = 1'b0;
  logic               cmd_ready_o;
  logic [KW-1:0]      cmd_k_i = '0;
  logic               cmd_clear_i = 1'b0;
  logic               in_valid_i = 1'b0;
  logic               in_ready_o;
  logic [ROWS*DW-1:0] in_a_i = '0;
  logic [COLS*DW-1:0] in_b_i = '0;
  logic               out_valid_o;
  logic               out_ready_i = 1'b0;
  logic [CW-1:0]      out_data_o;
  logic [RW-1:0]      out_row_o;
  logic               out_last_o;
  logic               busy_o;

  gemm_tile_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .KLEN_W(KW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_k_i(cmd_k_i), .cmd_clear_i(cmd_clear_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_row_o(out_row_o), .out_last_o(out_last_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int t0 = 0;
  int t1 = 0;

  typedef struct packed {
    logic [CW-1:0] data;
    logic [RW-1:0] row;
    logic          last;
  } exp_t;

  exp_t                     sb[$];
  logic [ROWS*DW-1:0]       qa[$];
  logic [COLS*DW-1:0]       qb[$];
  logic signed [AW-1:0]     mdl [ROWS][COLS];

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mdl[r][c] = '0;
  endtask

  // Plain matrix-product reference over the queued beats; pushes expected rows.
  task automatic model_cmd(input bit clr);
    logic signed [DW-1:0] av, bv;
    longint p;
    exp_t e;
    if (clr) zero_model();
    for (int i = 0; i < qa.size(); i++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          av = qa[i][r*DW +: DW];
          bv = qb[i][c*DW +: DW];
          p  = longint'(av) * longint'(bv);
          mdl[r][c] = mdl[r][c] + AW'(p);
        end
    for (int r = 0; r < ROWS; r++) begin
      e.data = '0;
      for (int c = 0; c < COLS; c++) e.data[c*AW +: AW] = mdl[r][c];
      e.row  = RW'(r);
      e.last = (r == ROWS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic set_uniform(input int k, input int av, input int bv);
    logic [ROWS*DW-1:0] va;
    logic [COLS*DW-1:0] vb;
    qa.delete(); qb.delete();
    for (int r = 0; r < ROWS; r++) va[r*DW +: DW] = DW'(av);
    for (int c = 0; c < COLS; c++) vb[c*DW +: DW] = DW'(bv);
    for (int i = 0; i < k; i++) begin qa.push_back(va); qb.push_back(vb); end
  endtask

  task automatic set_identity();
    logic [ROWS*DW-1:0] va;
    logic [COLS*DW-1:0] vb;
    qa.delete(); qb.delete();
    for (int k = 0; k < 4; k++) begin
      va = '0;
      va[k*DW +: DW] = DW'(1);
      for (int c = 0; c < COLS; c++) vb[c*DW +: DW] = DW'(4*k + c + 1);
      qa.push_back(va); qb.push_back(vb);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_cmd(input bit clr, input int k);
    int g = 0;
    cmd_valid_i = 1'b1; cmd_k_i = KW'(k); cmd_clear_i = clr;
    #1;
    while (!cmd_ready_o && g < 50) begin @(negedge clk_i); #1; g++; end
    check("cmd_ready_idle", CW'(cmd_ready_o), CW'(1));
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    t0 = cyc;
    check("cmd_ready_busy", CW'(cmd_ready_o), CW'(0));
    check("busy_after_accept", CW'(busy_o), CW'(1));
  endtask

  task automatic feed(input bit stall);
    int  i = 0;
    int  g = 0;
    bit  tog = 1'b1;
    while (i < qa.size() && g < 500) begin
      in_valid_i = stall ? tog : 1'b1;
      tog = ~tog;
      in_a_i = qa[i]; in_b_i = qb[i];
      #1;
      if (in_valid_i && in_ready_o) i++;
      @(negedge clk_i);
      g++;
    end
    check("beats_fed", CW'(i), CW'(qa.size()));
    // Junk offered after the last beat must be refused.
    in_valid_i = 1'b1; in_a_i = '1; in_b_i = '1;
    #1;
    check("in_ready_after_k", CW'(in_ready_o), CW'(0));
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int   got = 0;
    int   g = 0;
    int   w = 0;
    exp_t e;
    while (got < ROWS && g < 500) begin
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          check("scoreboard_empty", CW'(sb.size()), CW'(1));
          got = ROWS;
        end else begin
          e = sb[0];
          check("row_data", out_data_o, e.data);
          check("row_index", CW'(out_row_o), CW'(e.row));
          check("row_last", CW'(out_last_o), CW'(e.last));
          if (bp && w < 3) begin
            out_ready_i = 1'b0; w++;
          end else begin
            out_ready_i = 1'b1;
            void'(sb.pop_front());
            got++; w = 0;
            if (e.last) t1 = cyc + 1;
          end
        end
      end else begin
        out_ready_i = 1'b0;
      end
      @(negedge clk_i);
      g++;
    end
    out_ready_i = 1'b0;
    check("rows_drained", CW'(got), CW'(ROWS));
    check("idle_after_drain", CW'(busy_o), CW'(0));
    check("valid_after_drain", CW'(out_valid_o), CW'(0));
  endtask

  initial begin
    zero_model();
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_out_valid", CW'(out_valid_o), CW'(0));
    check("rst_in_ready", CW'(in_ready_o), CW'(0));
    check("rst_busy", CW'(busy_o), CW'(0));
    check("rst_out_data", out_data_o, CW'(0));
    check("rst_out_row", CW'(out_row_o), CW'(0));
    check("rst_out_last", CW'(out_last_o), CW'(0));
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("cmd_ready_release", CW'(cmd_ready_o), CW'(1));

    // Identity A times B, unbroken flow, end-to-end latency.
    set_identity(); model_cmd(1'b1);
    do_cmd(1'b1, 4); feed(1'b0); drain(1'b0);
    check("latency_accept_to_last", CW'(t1 - t0), CW'(4 + ROWS + COLS + ROWS));

    // Same product with input gaps.
    set_identity(); model_cmd(1'b1);
    do_cmd(1'b1, 4); feed(1'b1); drain(1'b0);

    // Same product with output backpressure.
    set_identity(); model_cmd(1'b1);
    do_cmd(1'b1, 4); feed(1'b0); drain(1'b1);

    // Accumulate across commands, then clear with K=0.
    set_uniform(1, 2, 3); model_cmd(1'b1);
    do_cmd(1'b1, 1); feed(1'b0); drain(1'b0);
    set_uniform(1, 2, 3); model_cmd(1'b0);
    do_cmd(1'b0, 1); feed(1'b0); drain(1'b0);
    set_uniform(0, 0, 0); model_cmd(1'b1);
    do_cmd(1'b1, 0); feed(1'b0); drain(1'b0);

    // Signed wrap and negative products.
    set_uniform(2, -32768, -32768); model_cmd(1'b1);
    do_cmd(1'b1, 2); feed(1'b0); drain(1'b0);
    set_uniform(1, -1, 5); model_cmd(1'b1);
    do_cmd(1'b1, 1); feed(1'b0); drain(1'b1);

    // Reset during the second LOAD beat of a K=4 command.
    set_uniform(4, 7, 9);
    do_cmd(1'b1, 4);
    in_valid_i = 1'b1; in_a_i = qa[0]; in_b_i = qb[0];
    @(negedge clk_i);
    in_a_i = qa[1]; in_b_i = qb[1];
    #2 rst_i = 1'b0;
    #1;
    check("midrst_out_valid", CW'(out_valid_o), CW'(0));
    check("midrst_in_ready", CW'(in_ready_o), CW'(0));
    check("midrst_busy", CW'(busy_o), CW'(0));
    check("midrst_out_data", out_data_o, CW'(0));
    check("midrst_out_row", CW'(out_row_o), CW'(0));
    check("midrst_out_last", CW'(out_last_o), CW'(0));
    in_valid_i = 1'b0;
    @(negedge clk_i);
    zero_model();
    qa.delete(); qb.delete();
    begin
      logic [ROWS*DW-1:0] va;
      logic [COLS*DW-1:0] vb;
      for (int r = 0; r < ROWS; r++) va[r*DW +: DW] = DW'(r + 1);
      for (int c = 0; c < COLS; c++) vb[c*DW +: DW] = DW'(c + 1);
      qa.push_back(va); qb.push_back(vb);
    end
    model_cmd(1'b0);
    rst_i = 1'b1;
    do_cmd(1'b0, 1);
    check("accept_first_clock", CW'(cyc - t0), CW'(0));
    feed(1'b0); drain(1'b0);

    check("scoreboard_drained", CW'(sb.size()), CW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
